id_ex_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fwd_select.sv | 45 ++++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core datapath.
// Holds the decoded control bundle, ALU operation codes and the zero register index.
package riscv_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding for one source register: picks the youngest matching
// producer (EX > MEM > WB) or falls back to the register file read data.
module fwd_select
    import riscv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            src_used,
    input  logic [4:0]      src_idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_wr,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_ok,
    input  logic            mem_wr,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_ok,
    input  logic            wb_wr,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val,
    output logic            hazard
);

    // A producer writing x0 never matches because src_idx is known to be non-zero here.
    always_comb begin
        val    = '0;
        hazard = 1'b0;
        if (src_used && (src_idx != REG_ZERO)) begin
            if (ex_wr && (ex_rd == src_idx)) begin
                if (ex_ok) val = ex_data;
                else       hazard = 1'b1;
            end else if (mem_wr && (mem_rd == src_idx)) begin
                if (mem_ok) val = mem_data;
                else        hazard = 1'b1;
            end else if (wb_wr && (wb_rd == src_idx)) begin
                val = wb_data;
            end else begin
                val = rf_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields with forwarded operands,
// inserts bubbles on unresolved data hazards and counts them.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  ctrl_t           id_ctrl,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_result_ok,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            mem_result_ok,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rd,
    output ctrl_t           ex_ctrl,
    output logic [CNTW-1:0] bubble_cnt
);

    logic            ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0] ex_imm_q,     ex_imm_d;
    logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d;
    logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d;
    logic [4:0]      ex_rd_q,      ex_rd_d;
    ctrl_t           ex_ctrl_q,    ex_ctrl_d;
    logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

    logic            adv;
    logic            ex_wr;
    logic            hazard;
    logic            hz1, hz2;
    logic [XLEN-1:0] fwd1, fwd2;

    assign ex_wr = ex_valid_q && ex_ctrl_q.reg_write;

    fwd_select #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_used (id_use_rs1),
        .src_idx  (id_rs1),
        .rf_data  (rf_rd1),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd_q),
        .ex_data  (ex_result),
        .ex_ok    (ex_result_ok),
        .mem_wr   (mem_reg_write),
        .mem_rd   (mem_rd),
        .mem_data (mem_result),
        .mem_ok   (mem_result_ok),
        .wb_wr    (wb_reg_write),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (fwd1),
        .hazard   (hz1)
    );

    fwd_select #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_used (id_use_rs2),
        .src_idx  (id_rs2),
        .rf_data  (rf_rd2),
        .ex_wr    (ex_wr),
        .ex_rd    (ex_rd_q),
        .ex_data  (ex_result),
        .ex_ok    (ex_result_ok),
        .mem_wr   (mem_reg_write),
        .mem_rd   (mem_rd),
        .mem_data (mem_result),
        .mem_ok   (mem_result_ok),
        .wb_wr    (wb_reg_write),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (fwd2),
        .hazard   (hz2)
    );

    assign adv      = !ex_valid_q || ex_ready;
    assign hazard   = hz1 || hz2;
    assign id_ready = flush || (adv && !hazard);

    // Flush kills the EX slot even when EX is stalled; payload only moves on capture.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_rd_d      = ex_rd_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            if (id_valid && hazard) begin
                ex_valid_d = 1'b0;
                if (bubble_cnt_q != {CNTW{1'b1}}) bubble_cnt_d = bubble_cnt_q + 1'b1;
            end else if (id_valid) begin
                ex_valid_d   = 1'b1;
                ex_pc_d      = id_pc;
                ex_imm_d     = id_imm;
                ex_rs1_val_d = fwd1;
                ex_rs2_val_d = fwd2;
                ex_rd_d      = id_rd;
                ex_ctrl_d    = id_ctrl;
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_rd      = ex_rd_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use bubbles, flush,
// counter saturation and asynchronous reset.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    ctrl_t           id_ctrl;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic [XLEN-1:0] ex_result;
    logic            ex_result_ok;
    logic            mem_reg_write;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            mem_result_ok;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]      ex_rd;
    ctrl_t           ex_ctrl;
    logic [CNTW-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_ctrl       (id_ctrl),
        .rf_rd1        (rf_rd1),
        .rf_rd2        (rf_rd2),
        .ex_result     (ex_result),
        .ex_result_ok  (ex_result_ok),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .mem_result_ok (mem_result_ok),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1_val    (ex_rs1_val),
        .ex_rs2_val    (ex_rs2_val),
        .ex_rd         (ex_rd),
        .ex_ctrl       (ex_ctrl),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time 2 units past the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_ctrl = '0;
        rf_rd1 = '0; rf_rd2 = '0;
        ex_result = '0; ex_result_ok = 1'b1;
        mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0; mem_result_ok = 1'b1;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        #11 rst_n = 1'b1;

        // add x3,x1,x2 with x1=0x11, x2=0x22 from the register file
        id_valid = 1'b1; id_pc = 32'h100; id_imm = 32'h4;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_ctrl = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0, alu_op:ALU_ADD};
        rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        #1 chk("t1_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("t1_ex_valid", 32'(ex_valid), 32'd1);
        chk("t1_rs1", ex_rs1_val, 32'h11);
        chk("t1_rs2", ex_rs2_val, 32'h22);
        chk("t1_pc", ex_pc, 32'h100);
        chk("t1_rd", 32'(ex_rd), 32'd3);

        // WB writes x5=0xDEAD while rf_rd1 still returns stale 0
        id_pc = 32'h104; id_rs1 = 5'd5; id_rd = 5'd5; rf_rd1 = 32'h0;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
        tick();
        chk("wb_fwd_rs1", ex_rs1_val, 32'hDEAD);
        chk("wb_fwd_rs2_rf", ex_rs2_val, 32'h22);

        // EX (captured rd=5) =1, MEM x5=2, WB x5=3: youngest wins
        id_pc = 32'h108; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd0;
        ex_result = 32'd1; ex_result_ok = 1'b1;
        mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'd2; mem_result_ok = 1'b1;
        wb_data = 32'd3;
        tick();
        chk("prio_rs1", ex_rs1_val, 32'd1);
        chk("prio_rs2", ex_rs2_val, 32'd1);

        // Sources x0, every producer rd=0 (EX rd captured as 0 above), unavailable EX data
        id_pc = 32'h10C; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd9;
        rf_rd1 = 32'h55; rf_rd2 = 32'h66;
        ex_result = 32'h77; ex_result_ok = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        #1 chk("x0_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("x0_rs1", ex_rs1_val, 32'd0);
        chk("x0_rs2", ex_rs2_val, 32'd0);
        chk("x0_bubble_cnt", 32'(bubble_cnt), 32'd0);

        // lw x6,0(x1) enters EX
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; ex_result_ok = 1'b1;
        id_pc = 32'h110; id_rs1 = 5'd1; id_rs2 = 5'd0; id_rd = 5'd6;
        id_use_rs2 = 1'b0; rf_rd1 = 32'h11; rf_rd2 = 32'h0;
        id_ctrl = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, alu_src:1'b1, alu_op:ALU_ADD};
        tick();
        chk("lw_ctrl", 32'(ex_ctrl), 32'(8'hD0));

        // add x7,x6,x6 in ID while the load is in EX
        id_pc = 32'h114; id_rs1 = 5'd6; id_rs2 = 5'd6; id_rd = 5'd7; id_use_rs2 = 1'b1;
        id_ctrl = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0, alu_op:ALU_ADD};
        rf_rd1 = 32'h0; rf_rd2 = 32'h0; ex_result_ok = 1'b0;
        #1 chk("lu1_id_ready", 32'(id_ready), 32'd0);
        tick();
        chk("lu1_ex_valid", 32'(ex_valid), 32'd0);
        chk("lu1_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Load now in MEM, data not yet back
        mem_reg_write = 1'b1; mem_rd = 5'd6; mem_result = 32'h0; mem_result_ok = 1'b0;
        #1 chk("lu2_id_ready", 32'(id_ready), 32'd0);
        tick();
        chk("lu2_ex_valid", 32'(ex_valid), 32'd0);
        chk("lu2_bubble_cnt", 32'(bubble_cnt), 32'd2);

        // Load in WB; operand forwarded from wb_data
        mem_reg_write = 1'b0; mem_result_ok = 1'b1; ex_result_ok = 1'b1;
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_data = 32'hBEEF;
        #1 chk("lu3_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("lu3_ex_valid", 32'(ex_valid), 32'd1);
        chk("lu3_rs1", ex_rs1_val, 32'hBEEF);
        chk("lu3_rs2", ex_rs2_val, 32'hBEEF);
        chk("lu3_bubble_cnt", 32'(bubble_cnt), 32'd2);

        // Flush with a hazard pending on x7 and EX stalled
        wb_reg_write = 1'b0;
        id_pc = 32'h118; id_rs1 = 5'd7; id_rs2 = 5'd0; id_rd = 5'd8;
        ex_result_ok = 1'b0; ex_ready = 1'b0; flush = 1'b1;
        #1 chk("fl_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_bubble_cnt", 32'(bubble_cnt), 32'd2);
        chk("fl_rd_held", 32'(ex_rd), 32'd7);

        // Continuous MEM hazard on x4 drives the counter to saturation
        flush = 1'b0; ex_ready = 1'b1; ex_result_ok = 1'b1;
        id_rs1 = 5'd4; mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result_ok = 1'b0;
        repeat (65533) tick();
        chk("sat_reach", 32'(bubble_cnt), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(bubble_cnt), 32'hFFFF);
        chk("sat_ex_valid", 32'(ex_valid), 32'd0);

        // Asynchronous reset in the middle of the stall
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("arst_rs1", ex_rs1_val, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        chk("arst_ctrl", 32'(ex_ctrl), 32'd0);
        #3 rst_n = 1'b1;
        mem_reg_write = 1'b0; mem_result_ok = 1'b1;
        id_pc = 32'h200; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd10;
        rf_rd1 = 32'hA5; rf_rd2 = 32'h5A;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_rs1", ex_rs1_val, 32'hA5);
        chk("post_rst_cnt", 32'(bubble_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
